// File: rtl/clken_pkg.sv
// clken_pkg: shared defaults, lock state type and channel-index width helper for clken_gen
package clken_pkg;

    localparam int ACC_W_DEF       = 32;
    localparam int LOCK_CYCLES_DEF = 16;

    typedef enum logic {
        LOCKING = 1'b0,
        LOCKED  = 1'b1
    } lock_state_t;

    // Width of a channel index; a single channel still gets a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clken_phase_acc.sv
// clken_phase_acc: one phase-accumulator channel producing a registered carry (and optional MSB)
//   refclk  in  clock, rst in sync active-high reset
//   i_wr    in  load i_inc into the increment register
//   i_inc   in  new increment value
//   i_sync  in  clear accumulator and pending carry
//   o_carry out registered carry of acc+inc
//   o_msb   out registered accumulator MSB (only with CLKEN_GEN_SQ_EN)
module clken_phase_acc
    import clken_pkg::*;
#(
    parameter int               ACC_W   = ACC_W_DEF,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [ACC_W-1:0] i_inc,
    input  logic             i_sync,
    output logic             o_carry
`ifdef CLKEN_GEN_SQ_EN
   ,output logic             o_msb
`endif
);

    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_acc;
    logic             r_carry;
    logic [ACC_W:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
    assign o_carry = r_carry;

    // The write only lands in r_inc, so the new increment is first summed one cycle later.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_inc   <= INC_RST;
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else begin
            if (i_wr)
                r_inc <= i_inc;
            r_acc   <= i_sync ? '0 : w_sum[ACC_W-1:0];
            r_carry <= ~i_sync & w_sum[ACC_W];
        end
    end

`ifdef CLKEN_GEN_SQ_EN
    logic r_msb;

    always_ff @(posedge refclk) begin
        if (rst || i_sync)
            r_msb <= 1'b0;
        else
            r_msb <= r_acc[ACC_W-1];
    end

    assign o_msb = r_msb;
`endif

endmodule

// File: rtl/clken_gen.sv
// clken_gen: multi-channel fractional clock-enable generator with PLL-style lock flag
//   refclk in  sole clock, rst in sync active-high reset
//   wr_en  in  increment write strobe; wr_ch target channel; wr_inc new increment
//   sync   in  clear all accumulators (phase alignment)
//   ce     out per-channel one-cycle enable pulses, gated by locked
//   locked out generator settled
//   sq     out 50% duty squares, gated by locked (only with CLKEN_GEN_SQ_EN)
module clken_gen
    import clken_pkg::*;
#(
    parameter int                      NUM_CH      = 3,
    parameter int                      ACC_W       = ACC_W_DEF,
    parameter int                      LOCK_CYCLES = LOCK_CYCLES_DEF,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = '0
) (
    input  logic                          refclk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [ch_idx_w(NUM_CH)-1:0]   wr_ch,
    input  logic [ACC_W-1:0]              wr_inc,
    input  logic                          sync,
    output logic [NUM_CH-1:0]             ce,
    output logic                          locked
`ifdef CLKEN_GEN_SQ_EN
   ,output logic [NUM_CH-1:0]             sq
`endif
);

    localparam int CW = $clog2(LOCK_CYCLES + 1);

    lock_state_t       r_state;
    lock_state_t       w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_wr_valid;
    logic              w_restart;
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_carry;
`ifdef CLKEN_GEN_SQ_EN
    logic [NUM_CH-1:0] w_msb;
`endif

    // Out-of-range channel writes are dropped completely, so they cannot disturb lock.
    assign w_wr_valid = wr_en && (32'(wr_ch) < NUM_CH);
    assign w_restart  = w_wr_valid || sync;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_wr[k] = w_wr_valid && (32'(wr_ch) == k);
        clken_phase_acc #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_INIT[k*ACC_W +: ACC_W])
        ) u_acc (
            .refclk  (refclk),
            .rst     (rst),
            .i_wr    (w_wr[k]),
            .i_inc   (wr_inc),
            .i_sync  (sync),
            .o_carry (w_carry[k])
`ifdef CLKEN_GEN_SQ_EN
           ,.o_msb   (w_msb[k])
`endif
        );
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state <= LOCKING;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_restart ? LOCKING :
                      (r_state == LOCKING && r_cnt == CW'(LOCK_CYCLES - 1)) ? LOCKED : r_state;
        w_cnt_nxt   = (w_restart || r_state == LOCKED) ? '0 : r_cnt + 1'b1;
    end

    always_comb begin
        locked = (r_state == LOCKED);
        ce     = w_carry & {NUM_CH{locked}};
`ifdef CLKEN_GEN_SQ_EN
        sq     = w_msb & {NUM_CH{locked}};
`endif
    end

endmodule

// File: tb/tb_clken_gen.sv
// tb_clken_gen: table-driven, directed and random checks of clken_gen against an arithmetic model
module tb_clken_gen;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int LC  = 16;
    localparam logic [NCH*AW-1:0] INC_INIT = {32'h0, 32'h0, 32'h4000_0000};

    logic           refclk = 1'b0;
    logic           rst    = 1'b1;
    logic           wr_en  = 1'b0;
    logic [1:0]     wr_ch  = '0;
    logic [AW-1:0]  wr_inc = '0;
    logic           sync   = 1'b0;
    logic [NCH-1:0] ce;
    logic           locked;
`ifdef CLKEN_GEN_SQ_EN
    logic [NCH-1:0] sq;
`endif

    always #5 refclk = ~refclk;

    clken_gen #(
        .NUM_CH      (NCH),
        .ACC_W       (AW),
        .LOCK_CYCLES (LC),
        .INC_INIT    (INC_INIT)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_inc (wr_inc),
        .sync   (sync),
        .ce     (ce),
        .locked (locked)
`ifdef CLKEN_GEN_SQ_EN
       ,.sq     (sq)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cnt[NCH];

    // Model: accumulator as a plain integer, pulse whenever the sum crosses 2^32;
    // locked once enough quiet cycles have passed since the last restart event.
    longint unsigned m_inc[NCH];
    longint unsigned m_acc[NCH];
    bit              m_pend[NCH];
    int              m_quiet = 0;
    logic [AW-1:0]   init_v;

    function automatic bit m_locked();
        return m_quiet >= LC;
    endfunction

    function automatic logic [NCH-1:0] m_ce();
        logic [NCH-1:0] r;
        for (int k = 0; k < NCH; k++) r[k] = m_pend[k] && m_locked();
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit valid;
        longint unsigned s;
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                init_v    = INC_INIT[k*AW +: AW];
                m_inc[k]  = init_v;
                m_acc[k]  = 0;
                m_pend[k] = 0;
            end
            m_quiet = 0;
        end else begin
            valid = wr_en && (int'(wr_ch) < NCH);
            for (int k = 0; k < NCH; k++) begin
                s         = m_acc[k] + m_inc[k];
                m_pend[k] = !sync && (s >= 64'h1_0000_0000);
                m_acc[k]  = sync ? 0 : (s % 64'h1_0000_0000);
                if (valid && int'(wr_ch) == k) m_inc[k] = wr_inc;
            end
            m_quiet = (valid || sync) ? 0 : ((m_quiet < 1000) ? m_quiet + 1 : m_quiet);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step();
        #1;
        check("ce", ce, m_ce());
        check("locked", locked, m_locked());
    endtask

    task automatic write(input int ch, input logic [AW-1:0] v, input bit s);
        wr_en  = 1'b1;
        wr_ch  = ch[1:0];
        wr_inc = v;
        sync   = s;
        tick();
        wr_en  = 1'b0;
        sync   = 1'b0;
    endtask

    task automatic wait_lock();
        for (int i = 0; i < 40 && !m_locked(); i++) tick();
        check("wait_lock", locked, 1);
    endtask

    task automatic count(input int n);
        for (int k = 0; k < NCH; k++) cnt[k] = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            for (int k = 0; k < NCH; k++) cnt[k] += int'(ce[k]);
        end
    endtask

    typedef struct {
        logic [AW-1:0] inc0, inc1, inc2;
        int            e0, e1, e2;
    } rate_t;

    rate_t tbl[4];

    initial begin
        tbl[0] = '{32'h4000_0000, 32'h8000_0000, 32'h0000_0000, 16, 32, 0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h2000_0000, 64, 0, 8};
        tbl[2] = '{32'h1000_0000, 32'hC000_0000, 32'h0800_0000, 4, 48, 2};
        tbl[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h4000_0000, 0, 64, 16};

        // Reset held 3 cycles, then exactly LC cycles unlocked with ce gated off.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < LC; i++) begin
            if (i > 0) tick();
            check("rst_lock_low", locked, 0);
            check("rst_ce_gated", ce, 0);
        end
        tick();
        check("rst_lock_high", locked, 1);

        // Rate table.
        foreach (tbl[t]) begin
            write(0, tbl[t].inc0, 0);
            write(1, tbl[t].inc1, 0);
            write(2, tbl[t].inc2, 0);
            sync = 1'b1;
            tick();
            sync = 1'b0;
            wait_lock();
            count(64);
            check($sformatf("rate%0d_ch0", t), cnt[0], tbl[t].e0);
            check($sformatf("rate%0d_ch1", t), cnt[1], tbl[t].e1);
            check($sformatf("rate%0d_ch2", t), cnt[2], tbl[t].e2);
        end

        // Fractional ratio over 2^16 cycles.
        write(2, 32'h0B5E_50F0, 1);
        wait_lock();
        count(65536);
        n_vec++;
        if (cnt[2] < 2909 || cnt[2] > 2911) begin
            n_err++;
            $display("FAIL frac_count: got %0d expected 2910 +/-1", cnt[2]);
        end

        // Out-of-range write leaves lock and state alone.
        write(0, 32'h4000_0000, 1);
        wait_lock();
        write(3, 32'h1234_5678, 0);
        check("oor_locked", locked, 1);
        count(64);
        check("oor_ch0", cnt[0], 16);
        check("oor_locked_after", locked, 1);

        // Write and sync together: new increment, phase cleared, lock restarts.
        write(0, 32'h8000_0000, 1);
        check("wrsync_unlocked", locked, 0);
        wait_lock();
        count(64);
        check("wrsync_ch0", cnt[0], 32);

        // Reset exactly when a ch0 pulse is due: pulse dropped, increments back to INC_INIT.
        write(1, 32'h8000_0000, 0);
        wait_lock();
        begin
            int i;
            for (i = 0; i < 10 && !((m_acc[0] + m_inc[0]) >= 64'h1_0000_0000); i++) tick();
            if (i == 10) begin
                n_vec++;
                n_err++;
                $display("FAIL rst_mid_search: no due pulse found");
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_drop", ce, 0);
        wait_lock();
        count(64);
        check("rst_mid_ch0", cnt[0], 16);
        check("rst_mid_ch1", cnt[1], 0);

`ifdef CLKEN_GEN_SQ_EN
        write(0, 32'h2000_0000, 1);
        wait_lock();
        begin
            int highs = 0, rises = 0;
            logic prev = sq[0];
            for (int i = 0; i < 64; i++) begin
                tick();
                highs += int'(sq[0]);
                rises += int'(sq[0] && !prev);
                prev = sq[0];
            end
            check("sq_high", highs, 32);
            check("sq_rises", rises, 8);
        end
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            wr_en  = ($urandom_range(0, 19) == 0);
            wr_ch  = 2'($urandom_range(0, 3));
            wr_inc = $urandom;
            sync   = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst   = 1'b0;
        wr_en = 1'b0;
        sync  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
